lcd_frame_writer: RTL and testbench

LCD_FRAME_WRITER -- requirements
Module: lcd_frame_writer

---
 rtl/lcd_frame_writer.sv | 168 ++++++++++++++++
 tb/tb_lcd_frame_writer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_writer.sv
// rtl/lcd_frame_writer.sv - HD44780 8-bit two-row frame writer with power-up init sequence
// Define LCD_REFRESH_EN to rewrite the frame continuously from a pending buffer.
module lcd_frame_writer #(
  parameter int TIME_20MS  = 1_000_000,
  parameter int TIME_500HZ = 100_000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [127:0] ROW1,
  input  logic [127:0] ROW2,
  input  logic         LOAD,
  output logic         READY,
  output logic         LCD_E,
  output logic         LCD_RS,
  output logic [7:0]   LCD_DATA
);

  localparam int CW = (TIME_500HZ > 2) ? $clog2(TIME_500HZ) : 1;
  localparam int PW = $clog2(TIME_20MS + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(TIME_500HZ - 1);
  localparam logic [CW-1:0] E_LAST    = CW'(TIME_500HZ / 2 - 1);
  localparam logic [PW-1:0] PWR_LAST  = PW'(TIME_20MS - 1);
  localparam logic [127:0]  SPACES    = {16{8'h20}};

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, ADDR1, CHR1, ADDR2, CHR2} state_t;

  state_t         state;
  logic [PW-1:0]  pwr_cnt;
  logic [CW-1:0]  slot_cnt;
  logic [3:0]     idx;
  logic [127:0]   shadow1;
  logic [127:0]   shadow2;
`ifdef LCD_REFRESH_EN
  logic [127:0]   pend1;
  logic [127:0]   pend2;
`endif

  // Column 0 lives in the top byte, so the byte offset is (15 - col).
  function automatic logic [7:0] col_byte(input logic [127:0] row, input logic [3:0] col);
    return row[{~col, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h38;
      3'd1:    return 8'h08;
      3'd2:    return 8'h01;
      3'd3:    return 8'h06;
      default: return 8'h0C;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= PWR_WAIT;
      pwr_cnt  <= '0;
      slot_cnt <= '0;
      idx      <= '0;
      shadow1  <= SPACES;
      shadow2  <= SPACES;
`ifdef LCD_REFRESH_EN
      pend1    <= SPACES;
      pend2    <= SPACES;
`endif
      READY    <= 1'b0;
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
    end else begin
`ifdef LCD_REFRESH_EN
      if (LOAD && READY) begin
        pend1 <= ROW1;
        pend2 <= ROW2;
      end
`endif
      case (state)
        PWR_WAIT: begin
          if (pwr_cnt == PWR_LAST) begin
            state    <= INIT;
            slot_cnt <= '0;
            idx      <= '0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= init_cmd(3'd0);
          end else begin
            pwr_cnt <= pwr_cnt + 1'b1;
          end
        end

        IDLE: begin
          if (LOAD && READY) begin
            shadow1  <= ROW1;
            shadow2  <= ROW2;
            state    <= ADDR1;
            slot_cnt <= '0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h80;
`ifndef LCD_REFRESH_EN
            READY    <= 1'b0;
`endif
          end
        end

        // Every remaining state is slot-driven: bus changes only when a new slot begins.
        default: begin
          if (slot_cnt != SLOT_LAST) begin
            slot_cnt <= slot_cnt + 1'b1;
            LCD_E    <= (slot_cnt < E_LAST);
          end else begin
            slot_cnt <= '0;
            LCD_E    <= 1'b0;
            case (state)
              INIT: begin
                if (idx == 4'd4) begin
                  state <= IDLE;
                  READY <= 1'b1;
                end else begin
                  idx      <= idx + 4'd1;
                  LCD_DATA <= init_cmd(idx[2:0] + 3'd1);
                end
              end
              ADDR1: begin
                state    <= CHR1;
                idx      <= '0;
                LCD_RS   <= 1'b1;
                LCD_DATA <= col_byte(shadow1, 4'd0);
              end
              CHR1: begin
                if (idx == 4'd15) begin
                  state    <= ADDR2;
                  LCD_RS   <= 1'b0;
                  LCD_DATA <= 8'hC0;
                end else begin
                  idx      <= idx + 4'd1;
                  LCD_DATA <= col_byte(shadow1, idx + 4'd1);
                end
              end
              ADDR2: begin
                state    <= CHR2;
                idx      <= '0;
                LCD_RS   <= 1'b1;
                LCD_DATA <= col_byte(shadow2, 4'd0);
              end
              CHR2: begin
                if (idx == 4'd15) begin
`ifdef LCD_REFRESH_EN
                  state    <= ADDR1;
                  shadow1  <= pend1;
                  shadow2  <= pend2;
                  LCD_RS   <= 1'b0;
                  LCD_DATA <= 8'h80;
`else
                  state    <= IDLE;
                  READY    <= 1'b1;
`endif
                end else begin
                  idx      <= idx + 4'd1;
                  LCD_DATA <= col_byte(shadow2, idx + 4'd1);
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// tb/tb_lcd_frame_writer.sv - directed bench for lcd_frame_writer (TIME_20MS=20, TIME_500HZ=8)
module tb_lcd_frame_writer;

  localparam int T20 = 20;
  localparam int T5  = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [127:0] ROW1 = '0;
  logic [127:0] ROW2 = '0;
  logic         LOAD = 1'b0;
  logic         READY;
  logic         LCD_E;
  logic         LCD_RS;
  logic [7:0]   LCD_DATA;

  lcd_frame_writer #(.TIME_20MS(T20), .TIME_500HZ(T5)) dut (
    .CLK(CLK), .RST(RST), .ROW1(ROW1), .ROW2(ROW2), .LOAD(LOAD),
    .READY(READY), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_DATA(LCD_DATA)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;

  logic [8:0] wq[$];
  int strobe_err = 0;
  int strobe_pulses = 0;

  typedef struct {
    logic [127:0] r1;
    logic [127:0] r2;
    logic [7:0]   e1_0;
    logic [7:0]   e1_5;
    logic [7:0]   e2_15;
  } frame_vec_t;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Bus monitor: records {RS,DATA} at each LCD_E fall and checks slot strobe shape.
  initial begin
    logic       e_prev;
    logic [8:0] prev_bus;
    logic [8:0] lat_bus;
    int         ph;
    e_prev = 1'b0; prev_bus = '0; lat_bus = '0; ph = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        e_prev = 1'b0;
        ph = 0;
      end else begin
        if (e_prev && !LCD_E) wq.push_back({LCD_RS, LCD_DATA});
        if (ph == 0) begin
          if (LCD_E && !e_prev) begin
            ph = 1;
            lat_bus = prev_bus;
            strobe_pulses++;
            if ({LCD_RS, LCD_DATA} !== lat_bus) strobe_err++;
          end
        end else begin
          ph++;
          if (LCD_E !== (ph <= 3)) strobe_err++;
          if ({LCD_RS, LCD_DATA} !== lat_bus) strobe_err++;
          if (ph == 7) ph = 0;
        end
        e_prev = LCD_E;
      end
      prev_bus = {LCD_RS, LCD_DATA};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic logic [8:0] frame_exp(input logic [127:0] r1, input logic [127:0] r2, input int i);
    if (i == 0)  return {1'b0, 8'h80};
    if (i <= 16) return {1'b1, r1[8*(17-i)-1 -: 8]};
    if (i == 17) return {1'b0, 8'hC0};
    return {1'b1, r2[8*(17-(i-17))-1 -: 8]};
  endfunction

  task automatic wait_writes(input int n, input int budget, input string nm);
    int c = 0;
    while (wq.size() < n && c < budget) begin
      @(negedge CLK);
      c++;
    end
    chk(nm, (wq.size() >= n), 1);
  endtask

  task automatic pop_write(output logic [8:0] w);
    if (wq.size() > 0) w = wq.pop_front();
    else w = 9'h1FF;
  endtask

  task automatic powerup();
    int n;
    logic [8:0] w;
    logic [7:0] cmds[5];
    cmds = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (!LCD_E && n < 100);
    chk_rng("pwr_delay", n, T20 + 1, T20 + 2);
    wait_writes(5, 80, "init_writes");
    chk("ready_during_init", READY, 0);
    for (int i = 0; i < 5; i++) begin
      pop_write(w);
      chk($sformatf("init_cmd%0d", i), w, {1'b0, cmds[i]});
    end
    n = 0;
    while (!READY && n < 2 * T5) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_after_init", READY, 1);
  endtask

  task automatic start_frame(input logic [127:0] r1, input logic [127:0] r2);
    int n = 0;
    while (!READY && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_before_load", READY, 1);
    wq.delete();
    ROW1 = r1;
    ROW2 = r2;
    LOAD = 1'b1;
    @(posedge CLK);
    #1;
    accept_cyc = cyc;
    LOAD = 1'b0;
    ROW1 = ~r1;
    ROW2 = r2 ^ {16{8'h5A}};
`ifndef LCD_REFRESH_EN
    chk("ready_drop", READY, 0);
`endif
    n = 0;
    while (!LCD_E && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk_rng("e_latency", n, 1, T5 + 2);
  endtask

  task automatic finish_frame(input logic [127:0] r1, input logic [127:0] r2, input string tag,
                              output logic [8:0] got[34]);
    int n = 0;
    while (!READY && n < 400) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk_rng({tag, "_ready_cycles"}, cyc - accept_cyc, 34 * T5, 35 * T5);
    chk({tag, "_write_count"}, wq.size(), 34);
    for (int i = 0; i < 34; i++) begin
      pop_write(got[i]);
      chk($sformatf("%s_w%0d", tag, i), got[i], frame_exp(r1, r2, i));
    end
  endtask

  initial begin
    frame_vec_t vecs[3];
    logic [8:0] got[34];
    logic [8:0] w;
    int n;

    vecs[0] = '{"     Song 1     ", "  Artist Name   ", 8'h20, 8'h53, 8'h20};
    vecs[1] = '{"0123456789ABCDEF", "fedcba9876543210", 8'h30, 8'h35, 8'h30};
    vecs[2] = '{128'h00FF55AA0102030405060708090A0B0C, {16{8'hA5}}, 8'h00, 8'h02, 8'hA5};

    repeat (3) @(negedge CLK);
    chk("rst_e", LCD_E, 0);
    chk("rst_rs", LCD_RS, 0);
    chk("rst_data", LCD_DATA, 8'h00);
    chk("rst_ready", READY, 0);

    powerup();

`ifndef LCD_REFRESH_EN
    for (int v = 0; v < 3; v++) begin
      start_frame(vecs[v].r1, vecs[v].r2);
      finish_frame(vecs[v].r1, vecs[v].r2, $sformatf("frame%0d", v), got);
      chk($sformatf("frame%0d_c1_0", v), got[1], {1'b1, vecs[v].e1_0});
      chk($sformatf("frame%0d_c1_5", v), got[6], {1'b1, vecs[v].e1_5});
      chk($sformatf("frame%0d_c2_15", v), got[33], {1'b1, vecs[v].e2_15});
    end

    // LOAD while busy must not alter the frame or queue another one.
    start_frame(vecs[0].r1, vecs[0].r2);
    wait_writes(6, 100, "busy_mid_chr1");
    chk("busy_ready_low", READY, 0);
    ROW1 = vecs[1].r1;
    ROW2 = vecs[1].r2;
    LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    finish_frame(vecs[0].r1, vecs[0].r2, "busy", got);
    repeat (3 * T5) @(negedge CLK);
    chk("busy_no_refire", wq.size(), 0);
    chk("busy_ready_idle", READY, 1);

    // Reset at CHR2 column 7 abandons the frame and reruns power-up.
    start_frame(vecs[1].r1, vecs[1].r2);
    wait_writes(25, 300, "reset_reach_chr2");
    n = 0;
    while (!LCD_E && n < 2 * T5) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("reset_e_high_before", LCD_E, 1);
    RST = 1'b1;
    #1;
    chk("reset_e_now", LCD_E, 0);
    chk("reset_data_now", LCD_DATA, 8'h00);
    chk("reset_rs_now", LCD_RS, 0);
    chk("reset_ready_now", READY, 0);
    repeat (3) @(negedge CLK);
    wq.delete();
    powerup();
`else
    start_frame(vecs[0].r1, vecs[0].r2);
    wait_writes(39, 400, "refresh_mid_frame2");
    chk("refresh_ready_high", READY, 1);
    ROW1 = vecs[1].r1;
    ROW2 = vecs[1].r2;
    LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    wait_writes(102, 900, "refresh_three_frames");
    for (int i = 0; i < 102; i++) begin
      pop_write(w);
      if (i < 68) chk($sformatf("refresh_w%0d", i), w, frame_exp(vecs[0].r1, vecs[0].r2, i % 34));
      else        chk($sformatf("refresh_w%0d", i), w, frame_exp(vecs[1].r1, vecs[1].r2, i % 34));
    end
    chk("refresh_ready_stays", READY, 1);
`endif

    chk("strobe_timing_errors", strobe_err, 0);
    chk("strobe_pulses_seen", (strobe_pulses >= 40), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
